// File: rtl/ov9281_capture.sv
// ov9281_capture: OV9281 DVP capture packing pixels into a first-word-fall-through AXI-Stream word FIFO
module ov9281_capture #(
  parameter int DATA_WIDTH = 32,
  parameter int PIX_WIDTH = 8,
  parameter int FRAME_WIDTH = 1280,
  parameter int FRAME_HEIGHT = 800,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_vsync,
  input  logic                  i_href,
  input  logic [PIX_WIDTH-1:0]  i_data,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic                  o_tvalid,
  input  logic                  i_tready,
  output logic                  o_tuser,
  output logic                  o_tlast,
  output logic                  o_frame_done,
  output logic                  o_overflow,
  output logic                  o_frame_err
);
  localparam int PPW = DATA_WIDTH / PIX_WIDTH;
  localparam int NW = PPW > 1 ? $clog2(PPW) : 1;
  localparam int CW = $clog2(FRAME_WIDTH + 1) + 1;
  localparam int LW = FRAME_HEIGHT > 1 ? $clog2(FRAME_HEIGHT) : 1;
  localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, WAIT_LINE, ACTIVE, DROP} state_t;
  state_t st, st_n;
  logic vs_r, vs_p, hr_r, hr_p, vs_rise, hr_rise;
  logic [PIX_WIDTH-1:0] d_r;
  logic [NW-1:0] n, n_n;
  logic [CW-1:0] col, col_n;
  logic [LW-1:0] line, line_n;
  logic [DATA_WIDTH-1:0] acc, acc_n, pw;
  logic pix, eol, clr, push, pu, pl, ovf_n, err_n, done_n;
  logic [AW:0] wp, wp1, wp2, rp;
  logic [DATA_WIDTH+1:0] mem [FIFO_DEPTH];
  logic full, pop, wr;
  assign vs_rise = vs_r & ~vs_p;
  assign hr_rise = hr_r & ~hr_p;
  assign full = (wp - rp) == (AW+1)'(FIFO_DEPTH);
  assign o_tvalid = wp2 != rp;
  assign pop = o_tvalid & i_tready;
  assign wr = push & (~full | pop);
  assign {o_tlast, o_tuser, o_tdata} = o_tvalid ? mem[rp[AW-1:0]] : '0;
  always_comb begin
    st_n = st;
    n_n = n;
    col_n = col;
    line_n = line;
    acc_n = acc;
    pw = acc;
    pu = 1'b0;
    pl = 1'b0;
    push = 1'b0;
    pix = 1'b0;
    eol = 1'b0;
    clr = 1'b0;
    ovf_n = o_overflow;
    err_n = o_frame_err;
    done_n = 1'b0;
    case (st)
      IDLE: if (vs_rise && i_enable) begin
        st_n = WAIT_LINE;
        ovf_n = 1'b0;
        err_n = 1'b0;
        clr = 1'b1;
      end
      WAIT_LINE: if (vs_rise) begin
        err_n = 1'b1;
        clr = 1'b1;
      end else if (hr_rise) begin
        st_n = ACTIVE;
        pix = 1'b1;
      end
      ACTIVE: if (vs_rise) begin
        st_n = WAIT_LINE;
        err_n = 1'b1;
        clr = 1'b1;
      end else begin
        pix = hr_r;
        eol = ~hr_r & hr_p;
      end
      DROP: if (vs_rise) begin
        st_n = i_enable ? WAIT_LINE : IDLE;
        ovf_n = i_enable ? 1'b0 : o_overflow;
        err_n = i_enable ? 1'b0 : o_frame_err;
        clr = i_enable;
      end
    endcase
    if (pix) begin
      acc_n = acc | (DATA_WIDTH'(d_r) << (n * PIX_WIDTH));
      pw = acc_n;
      n_n = (n == NW'(PPW - 1)) ? '0 : n + NW'(1);
      if (n == NW'(PPW - 1)) begin
        push = 1'b1;
        pu = line == '0 && col == '0;
        pl = (col + CW'(PPW)) == CW'(FRAME_WIDTH);
        col_n = col + CW'(PPW);
        acc_n = '0;
      end
    end
    if (eol) begin
      push = col != CW'(FRAME_WIDTH) && n != '0;
      err_n = col != CW'(FRAME_WIDTH) ? 1'b1 : err_n;
      pu = line == '0 && col == '0;
      pl = 1'b1;
      acc_n = '0;
      n_n = '0;
      col_n = '0;
      line_n = (line == LW'(FRAME_HEIGHT - 1)) ? '0 : line + LW'(1);
      done_n = line == LW'(FRAME_HEIGHT - 1);
      st_n = (line == LW'(FRAME_HEIGHT - 1)) ? IDLE : WAIT_LINE;
    end
    if (clr) begin
      n_n = '0;
      col_n = '0;
      line_n = '0;
      acc_n = '0;
    end
    if (push && full && !pop) begin
      ovf_n = 1'b1;
      done_n = 1'b0;
      st_n = DROP;
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      st <= IDLE;
      {vs_r, vs_p, hr_r, hr_p} <= '0;
      d_r <= '0;
      n <= '0;
      col <= '0;
      line <= '0;
      acc <= '0;
      {wp, wp1, wp2, rp} <= '0;
      {o_frame_done, o_overflow, o_frame_err} <= '0;
    end else begin
      st <= st_n;
      {vs_r, vs_p, hr_r, hr_p} <= {i_vsync, vs_r, i_href, hr_r};
      d_r <= i_data;
      n <= n_n;
      col <= col_n;
      line <= line_n;
      acc <= acc_n;
      wp <= wp + (AW+1)'(wr);
      wp1 <= wp;
      wp2 <= wp1;
      rp <= rp + (AW+1)'(pop);
      {o_frame_done, o_overflow, o_frame_err} <= {done_n, ovf_n, err_n};
      if (wr) mem[wp[AW-1:0]] <= {pl, pu, pw};
    end
  end
endmodule

// File: tb/tb_ov9281_capture.sv
// tb_ov9281_capture: scoreboard bench for ov9281_capture against a line/word reference model
module tb_ov9281_capture;
  localparam int DW = 32, PW = 8, FW = 8, FH = 2, FD = 2, PPW = DW / PW;
  logic clk = 0, rst = 0, en = 0, vs = 0, hr = 0, tready = 1;
  logic [PW-1:0] din = 0;
  logic [DW-1:0] tdata;
  logic tvalid, tuser, tlast, done, ovf, ferr;
  int errors = 0, checks = 0, cyc = 0, done_cnt = 0, rdy_mode = 0, lat_t = 0;
  bit lat_arm = 0, stall = 0;
  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] held, e;

  ov9281_capture #(.DATA_WIDTH(DW), .PIX_WIDTH(PW), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .FIFO_DEPTH(FD)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_vsync(vs), .i_href(hr), .i_data(din),
    .o_tdata(tdata), .o_tvalid(tvalid), .i_tready(tready), .o_tuser(tuser), .o_tlast(tlast),
    .o_frame_done(done), .o_overflow(ovf), .o_frame_err(ferr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    tick();
    tready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'b0 : ((cyc % 2 == 1) || ($urandom % 2 == 1));
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (lat_arm && tvalid) begin
      chk("latency", 64'(cyc - lat_t), 4);
      lat_arm = 0;
    end
    if (stall) begin
      chk("stall_valid", tvalid, 1);
      chk("stall_hold", {tlast, tuser, tdata}, held);
    end
    stall = tvalid && !tready && rst;
    held = {tlast, tuser, tdata};
    if (tvalid && tready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got %h expected none", {tlast, tuser, tdata});
      end else begin
        e = exp_q.pop_front();
        if ({tlast, tuser, tdata} !== e) begin
          errors++;
          $display("FAIL word: got %h expected %h", {tlast, tuser, tdata}, e);
        end
      end
    end
  end

  task automatic vs_pulse();
    vs = 1;
    tick();
    tick();
    vs = 0;
    repeat (3) tick();
  endtask

  task automatic send_line(input int len, input int ln, input bit seq, inout logic [7:0] nxt,
                           inout int nw, input int maxw, input bit arm);
    logic [7:0] px [FW];
    logic [DW-1:0] d;
    logic last, user;
    for (int i = 0; i < len; i++) begin
      px[i] = seq ? nxt : 8'($urandom);
      if (seq) nxt++;
    end
    for (int w = 0; w * PPW < len; w++) begin
      d = '0;
      for (int j = 0; j < PPW && w * PPW + j < len; j++) d |= DW'(px[w * PPW + j]) << (8 * j);
      last = ((w + 1) * PPW >= len) && (len == FW || len % PPW != 0);
      user = ln == 0 && w == 0;
      if (nw < maxw) exp_q.push_back({last, user, d});
      nw++;
    end
    for (int i = 0; i < len; i++) begin
      hr = 1;
      din = px[i];
      if (arm && i == PPW - 1) begin
        lat_arm = 1;
        lat_t = cyc;
      end
      tick();
    end
    hr = 0;
    din = 0;
    repeat (4) tick();
  endtask

  task automatic frame(input int l0, input int l1, input bit seq, input int maxw, input bit arm,
                       input bit drop_en, input int exp_done, input bit exp_err, input bit exp_ovf, input string tag);
    logic [7:0] nxt = 1;
    int nw = 0;
    int d0 = done_cnt;
    bit en0 = en;
    vs_pulse();
    if (drop_en) en = 0;
    send_line(l0, 0, seq, nxt, nw, maxw, arm);
    send_line(l1, 1, seq, nxt, nw, maxw, 0);
    en = en0;
    repeat (12) tick();
    chk({tag, "_done"}, 64'(done_cnt - d0), 64'(exp_done));
    chk({tag, "_err"}, ferr, exp_err);
    chk({tag, "_ovf"}, ovf, exp_ovf);
  endtask

  initial begin
    logic [7:0] nxt;
    int nw, d0, l0, l1;
    rst = 0;
    repeat (3) tick();
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tuser", tuser, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_err", ferr, 0);
    rst = 1;
    en = 1;
    tick();
    frame(8, 8, 1, 99, 1, 0, 1, 0, 0, "basic");
    chk("latency_seen", lat_arm, 0);
    lat_arm = 0;
    frame(6, 8, 1, 99, 0, 0, 1, 1, 0, "short");
    nxt = 1;
    nw = 0;
    d0 = done_cnt;
    vs_pulse();
    send_line(8, 0, 1, nxt, nw, 99, 0);
    hr = 1;
    din = 8'hA1;
    tick();
    din = 8'hA2;
    tick();
    vs = 1;
    din = 8'hA3;
    tick();
    hr = 0;
    din = 0;
    tick();
    vs = 0;
    repeat (3) tick();
    send_line(8, 0, 1, nxt, nw, 99, 0);
    send_line(8, 1, 1, nxt, nw, 99, 0);
    repeat (12) tick();
    chk("restart_done", 64'(done_cnt - d0), 1);
    chk("restart_err", ferr, 1);
    rdy_mode = 1;
    tick();
    frame(8, 8, 1, 2, 0, 0, 0, 0, 1, "overflow");
    chk("ovf_hold_valid", tvalid, 1);
    chk("ovf_hold_data", tdata, 32'h04030201);
    chk("ovf_hold_user", tuser, 1);
    rdy_mode = 0;
    repeat (10) tick();
    chk("ovf_drained", exp_q.size(), 0);
    rdy_mode = 2;
    for (int f = 0; f < 8; f++) begin
      l0 = ($urandom % 3 == 0) ? $urandom_range(1, FW) : FW;
      l1 = ($urandom % 3 == 0) ? $urandom_range(1, FW) : FW;
      frame(l0, l1, 0, 99, 0, f % 2 == 1, 1, l0 != FW || l1 != FW, 0, "rand");
    end
    rdy_mode = 0;
    frame(8, 8, 0, 99, 0, 0, 1, 0, 0, "clean");
    en = 0;
    frame(8, 8, 1, 0, 0, 0, 0, 0, 0, "disabled");
    en = 1;
    rdy_mode = 1;
    tick();
    nxt = 1;
    nw = 0;
    vs_pulse();
    send_line(6, 0, 1, nxt, nw, 99, 0);
    hr = 1;
    for (int i = 0; i < 3; i++) begin
      din = 8'(8'h40 + i);
      tick();
    end
    chk("pre_rst_valid", tvalid, 1);
    chk("pre_rst_err", ferr, 1);
    rst = 0;
    hr = 0;
    din = 0;
    tick();
    chk("mid_rst_tvalid", tvalid, 0);
    chk("mid_rst_tdata", tdata, 0);
    chk("mid_rst_tuser", tuser, 0);
    chk("mid_rst_tlast", tlast, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_err", ferr, 0);
    exp_q.delete();
    rst = 1;
    rdy_mode = 0;
    d0 = done_cnt;
    for (int i = 0; i < FW; i++) begin
      hr = 1;
      din = 8'(i + 1);
      tick();
    end
    hr = 0;
    din = 0;
    repeat (12) tick();
    chk("no_vsync_valid", tvalid, 0);
    chk("no_vsync_done", 64'(done_cnt - d0), 0);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
